muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: RESET_HILO, default 32'h0, value loaded into HI and LO on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  launches an operation; sampled on the rising edge.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 rs_data  input  32  multiplicand or dividend; sampled with start.
REQ-007 rt_data  input  32  multiplier or divisor; sampled with start.
REQ-008 hi_we  input  1  MTHI strobe.
REQ-009 lo_we  input  1  MTLO strobe.
REQ-010 wdata  input  32  MTHI/MTLO data.
REQ-011 busy  output  1  operation in flight; the controller stalls MFHI/MFLO/MULT/DIV while it is high.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-013 div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with rt_data==0.
REQ-014 hi  output  32  HI register; the value MFHI passes to the register-file write data.
REQ-015 lo  output  32  LO register; the value MFLO passes to the register-file write data.

Function
REQ-016 The FSM SHALL have the states IDLE, MUL, DIV and DONE; busy=1 exactly in MUL and DIV; done=1 exactly in DONE.
REQ-017 In IDLE or DONE, start=1 SHALL latch the operands and go to MUL (op 0x) or DIV (op 1x), with iteration counter = 0.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 Signed ops SHALL convert operands to magnitude, iterate unsigned, and apply the sign to the result in the final iteration.
REQ-020 Multiply (iterative): shift-add, one bit per cycle, 32 cycles in MUL; the 32nd edge writes the 64-bit product as HI=[63:32] and LO=[31:0] and enters DONE.
REQ-021 Divide: restoring, one quotient bit per cycle, 32 cycles in DIV; the 32nd edge writes LO=quotient and HI=remainder and enters DONE.
REQ-022 Signed divide: the quotient sign SHALL be rs[31]^rt[31] and the remainder SHALL take the sign of the dividend; 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.
REQ-023 Divide by zero: the FSM SHALL go directly to DONE on the next edge with HI/LO unchanged and div_by_zero=1.
REQ-024 The latency from the start edge to done SHALL be 32 cycles for multiply and divide, and 1 cycle for divide by zero.
REQ-025 DONE SHALL go to IDLE on the next edge unless start=1.
REQ-026 hi_we/lo_we SHALL update HI/LO on the next edge only when busy=0 and start=0; they are ignored otherwise (start has priority).
REQ-027 HI/LO SHALL hold their prior values throughout MUL/DIV; intermediate state SHALL be kept in internal registers only.
REQ-028 The counter SHALL be 6 bits wide and SHALL never wrap mid-operation.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, HI=LO=RESET_HILO, busy=0, done=0, div_by_zero=0 and counter=0, aborting any operation in flight with no result written.
REQ-030 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-031 Macro: MULDIV_FAST_MULT_EN.
REQ-032 When MULDIV_FAST_MULT_EN is defined: MULT/MULTU SHALL compute the full product combinationally, enter DONE on the edge after start with HI/LO written (latency 1), and never enter MUL.
REQ-033 When MULDIV_FAST_MULT_EN is undefined: the 32-cycle iterative multiply of REQ-020 applies.
REQ-034 Divide behaviour SHALL be identical in both builds.

Verification
REQ-035 MULT rs=0xFFFFFFFE (-2), rt=3 -> done 32 cycles after start (1 if fast); HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 32 cycles (0 if fast).
REQ-037 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-038 DIVU 5 / 0 with HI=0x11, LO=0x22 -> done and div_by_zero high 1 cycle after start; HI/LO unchanged.
REQ-039 hi_we with wdata=0xABCD during busy -> ignored; after done, hi_we wdata=0xABCD -> hi=0xABCD on the next edge; start and lo_we in the same cycle -> lo_we dropped.
REQ-040 reset_n pulsed low at cycle 10 of DIVU 100/7 -> immediately IDLE, busy=0, HI=LO=RESET_HILO, no done pulse.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit for a MIPS-style pipeline.
// Iterative shift-add multiply and restoring divide, one bit per cycle,
// with signed operands handled as magnitudes and re-signed on the last step.
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU complete in one edge
// through a combinational multiplier and never enter the MUL state.
module muldiv_unit #(
    parameter logic [31:0] RESET_HILO = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      r_state, w_next_state;
    logic [5:0]  r_cnt;      // iteration index 0..31; stops at 32, never wraps
    logic [63:0] r_p;        // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
    logic [31:0] r_opa;      // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic        r_neg_q;    // negate product / quotient at the end
    logic        r_neg_r;    // negate remainder at the end
    logic        r_dbz;
    logic [31:0] r_hi, r_lo;

    // Operand conditioning: op[0]=0 selects the signed variants.
    logic        w_signed, w_rs_neg, w_rt_neg, w_div_zero, w_last;
    logic [31:0] w_rs_mag, w_rt_mag;
    logic [63:0] w_fast_prod;

    assign w_signed   = ~op[0];
    assign w_rs_neg   = w_signed & rs_data[31];
    assign w_rt_neg   = w_signed & rt_data[31];
    assign w_rs_mag   = w_rs_neg ? (32'h0 - rs_data) : rs_data;
    assign w_rt_mag   = w_rt_neg ? (32'h0 - rt_data) : rt_data;
    assign w_div_zero = op[1] & (rt_data == 32'h0);
    assign w_last     = (r_cnt == 6'd31);

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST_MULT = 1'b1;
    logic [63:0] w_ext_rs, w_ext_rt;
    // Sign/zero extension to 64 bits makes the truncated product correct for both MULT and MULTU.
    assign w_ext_rs    = {{32{w_rs_neg}}, rs_data};
    assign w_ext_rt    = {{32{w_rt_neg}}, rt_data};
    assign w_fast_prod = w_ext_rs * w_ext_rt;
`else
    localparam bit FAST_MULT = 1'b0;
    assign w_fast_prod = 64'h0;
`endif

    // One shift-add multiply step: add multiplicand if LSB set, shift right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next, w_mul_res;
    assign w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_opa} : 33'h0);
    assign w_mul_next = {w_mul_sum, r_p[31:1]};
    assign w_mul_res  = r_neg_q ? (64'h0 - w_mul_next) : w_mul_next;

    // One restoring divide step: shift in next dividend bit, subtract if it fits.
    // The shifted remainder minus divisor is always below 2^32 when non-negative,
    // so bit 32 of the trial is a clean borrow flag.
    logic [32:0] w_div_trial;
    logic [63:0] w_div_next;
    logic [31:0] w_quot, w_rem;
    assign w_div_trial = {r_p[63:32], r_p[31]} - {1'b0, r_opa};
    assign w_div_next  = w_div_trial[32] ? {r_p[62:0], 1'b0}
                                         : {w_div_trial[31:0], r_p[30:0], 1'b1};
    assign w_quot      = r_neg_q ? (32'h0 - w_div_next[31:0])  : w_div_next[31:0];
    assign w_rem       = r_neg_r ? (32'h0 - w_div_next[63:32]) : w_div_next[63:32];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic and status outputs.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no inferred latch).
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done         = (r_state == DONE);
                w_next_state = IDLE;
                if (start) begin
                    if (op[1])          w_next_state = w_div_zero ? DONE : DIV;
                    else if (FAST_MULT) w_next_state = DONE;
                    else                w_next_state = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO write-back and MTHI/MTLO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 6'd0;
            r_p     <= 64'h0;
            r_opa   <= 32'h0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= RESET_HILO;
            r_lo    <= RESET_HILO;
        end else begin
            r_dbz <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_cnt   <= 6'd0;
                        r_neg_q <= w_rs_neg ^ w_rt_neg;
                        r_neg_r <= w_rs_neg;
                        if (op[1]) begin
                            r_opa <= w_rt_mag;
                            r_p   <= {32'h0, w_rs_mag};
                            r_dbz <= w_div_zero;
                        end else begin
                            r_opa <= w_rs_mag;
                            r_p   <= {32'h0, w_rt_mag};
                            if (FAST_MULT) {r_hi, r_lo} <= w_fast_prod;
                        end
                    end else begin
                        // start has priority over MTHI/MTLO
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                MUL: begin
                    r_p   <= w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) {r_hi, r_lo} <= w_mul_res;
                end
                DIV: begin
                    r_p   <= w_div_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit.
// Latency is counted as edges after the edge that samples start before done
// is seen: 32 for iterative ops, 0 when DONE is entered on the start edge
// (divide by zero, fast multiply).
module tb_muldiv_unit;

    localparam logic [31:0] RST_VAL = 32'hDEADBEEF;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    muldiv_unit #(.RESET_HILO(RST_VAL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_applied = 0;
    int n_miss    = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs, rt, exp_hi, exp_lo;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            step();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt;
        string tag;

        //            op        rs            rt            exp_hi        exp_lo        dbz   lat
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, MUL_LAT};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT};
        vecs[2]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0, MUL_LAT};
        vecs[3]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, MUL_LAT};
        vecs[4]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, MUL_LAT};
        vecs[5]  = '{OP_MULT,  32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, MUL_LAT};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT};
        vecs[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, DIV_LAT};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, DIV_LAT};
        vecs[10] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, DIV_LAT};
        vecs[12] = '{OP_DIVU,  32'h80000000, 32'h00000010, 32'h00000000, 32'h08000000, 1'b0, DIV_LAT};
        vecs[13] = '{OP_DIVU,  32'd3,        32'd10,       32'd3,        32'd0,        1'b0, DIV_LAT};
        // divide by zero leaves HI/LO from the previous vector untouched
        vecs[14] = '{OP_DIV,   32'hFFFFFFFF, 32'h00000000, 32'd3,        32'd0,        1'b1, 0};
        vecs[15] = '{OP_DIVU,  32'd5,        32'h00000000, 32'd3,        32'd0,        1'b1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi",   hi, RST_VAL);
        check("reset_lo",   lo, RST_VAL);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dbz",  32'(div_by_zero), 32'd0);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bcnt);
            tag = $sformatf("v%0d", i);
            check({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({tag, "_busy_cycles"}, 32'(bcnt), 32'(vecs[i].exp_lat));
            check({tag, "_hi"}, hi, vecs[i].exp_hi);
            check({tag, "_lo"}, lo, vecs[i].exp_lo);
            check({tag, "_dbz"}, 32'(div_by_zero), 32'(vecs[i].exp_dbz));
            step();
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
        end

        // MTHI/MTLO then DIVU 5/0: HI/LO preserved
        hi_we = 1'b1; wdata = 32'h11; step(); hi_we = 1'b0;
        lo_we = 1'b1; wdata = 32'h22; step(); lo_we = 1'b0;
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        run_op(OP_DIVU, 32'd5, 32'd0, lat, bcnt);
        check("dbz_latency", 32'(lat), 32'd0);
        check("dbz_flag", 32'(div_by_zero), 32'd1);
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);
        step();
        check("dbz_flag_pulse", 32'(div_by_zero), 32'd0);

        // hi_we and a second start during busy are both ignored
        op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        repeat (3) begin step(); lat++; end
        hi_we = 1'b1; wdata = 32'hABCD;
        op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd3; start = 1'b1;
        step(); lat++;
        hi_we = 1'b0; start = 1'b0;
        check("busy_hold_hi", hi, 32'h11);
        check("busy_flag", 32'(busy), 32'd1);
        while (!done && lat < 40) begin step(); lat++; end
        check("busy_ignore_latency", 32'(lat), 32'(DIV_LAT));
        check("busy_ignore_hi", hi, 32'd2);
        check("busy_ignore_lo", lo, 32'd14);

        // MTHI after done takes effect on the next edge
        step();
        hi_we = 1'b1; wdata = 32'hABCD;
        step();
        hi_we = 1'b0;
        check("mthi_after_done", hi, 32'hABCD);

        // start and lo_we together: lo_we dropped
        op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        lo_we = 1'b1; wdata = 32'h5555;
        step();
        start = 1'b0; lo_we = 1'b0;
        check("start_prio_lo", lo, 32'd14);
        check("start_prio_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin step(); lat++; end
        check("start_prio_latency", 32'(lat), 32'(DIV_LAT));
        check("start_prio_lo_final", lo, 32'd14);

        // Reset in the middle of DIVU 100/7
        step();
        op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dbz",  32'(div_by_zero), 32'd0);
        check("abort_hi", hi, RST_VAL);
        check("abort_lo", lo, RST_VAL);
        step();
        check("abort_hold_done", 32'(done), 32'd0);

        // First start accepted on the first edge after reset release
        reset_n = 1'b1;
        run_op(OP_MULTU, 32'd3, 32'd5, lat, bcnt);
        check("post_reset_latency", 32'(lat), 32'(MUL_LAT));
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
